// File: rtl/lcd_win_writer_if.sv
// Pixel-in and panel-out signals of the LCD window writer.
// master = the writer block, slave = controller/panel side.
interface lcd_win_writer_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic [DW-1:0] panel_data;
    logic [1:0]    panel_row;
    logic [1:0]    panel_col;
    logic          panel_we;
    logic          panel_ready;
    logic          frame_done;
    logic          drop_err;
    logic [1:0]    buf_level;

    modport master (
        input  pix_in, pix_valid, panel_ready,
        output panel_data, panel_row, panel_col, panel_we, frame_done, drop_err, buf_level
    );

    modport slave (
        output pix_in, pix_valid, panel_ready,
        input  panel_data, panel_row, panel_col, panel_we, frame_done, drop_err, buf_level
    );
endinterface

// File: rtl/lcd_win_writer.sv
// Double-buffers 3x3 pixel windows from the LCD controller and writes them to
// the panel over a valid/ready port; drops whole frames when both buffers are full.
module lcd_win_writer #(
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    lcd_win_writer_if.master  bus
);
    localparam int unsigned NPIX = 9;
    localparam int unsigned CW   = 4;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    logic [DW-1:0] r_buf [2][NPIX];
    logic [1:0]    r_full;
    logic [1:0]    w_full_n;
    logic [1:0]    r_buf_level;

    logic          r_wsel;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] r_dcnt;
    logic          r_dropping;
    logic          r_drop_err;

    state_t        r_state, w_state_n;
    logic          r_rsel, w_rsel_n;
    logic [1:0]    r_row, w_row_n;
    logic [1:0]    r_col, w_col_n;
    logic          r_we, w_we_n;
    logic          r_frame_done, w_frame_done_n;
    logic [DW-1:0] r_data, w_data_n;
    logic [CW-1:0] w_idx;
    logic          w_accept;

    logic          w_drop_start;
    logic          w_store;
    logic          w_last_store;

    // A new frame targeting a still-occupied buffer is discarded in full.
    assign w_drop_start = bus.pix_valid && !r_dropping && (r_wcnt == '0) && r_full[r_wsel];
    assign w_store      = bus.pix_valid && !r_dropping && !w_drop_start;
    assign w_last_store = w_store && (r_wcnt == CW'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_wsel][r_wcnt] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wsel     <= 1'b0;
            r_wcnt     <= '0;
            r_dcnt     <= '0;
            r_dropping <= 1'b0;
            r_drop_err <= 1'b0;
        end else if (w_drop_start) begin
            r_dropping <= 1'b1;
            r_drop_err <= 1'b1;
            r_dcnt     <= CW'(1);
        end else if (bus.pix_valid && r_dropping) begin
            if (r_dcnt == CW'(NPIX - 1)) begin
                r_dropping <= 1'b0;
                r_dcnt     <= '0;
            end else begin
                r_dcnt <= r_dcnt + CW'(1);
            end
        end else if (w_store) begin
            if (w_last_store) begin
                r_wcnt <= '0;
                r_wsel <= ~r_wsel;
            end else begin
                r_wcnt <= r_wcnt + CW'(1);
            end
        end
    end

    // Capture and release always touch different buffers, so both apply.
    always_comb begin
        w_full_n = r_full;
        if (r_state == DONE) begin
            w_full_n[r_rsel] = 1'b0;
        end
        if (w_last_store) begin
            w_full_n[r_wsel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full      <= '0;
            r_buf_level <= '0;
        end else begin
            r_full      <= w_full_n;
            r_buf_level <= 2'(r_full[0]) + 2'(r_full[1]);
        end
    end

    assign w_accept = r_we && bus.panel_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rsel       <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_n;
            r_rsel       <= w_rsel_n;
            r_row        <= w_row_n;
            r_col        <= w_col_n;
            r_we         <= w_we_n;
            r_frame_done <= w_frame_done_n;
            r_data       <= w_data_n;
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        w_state_n      = r_state;
        w_rsel_n       = r_rsel;
        w_row_n        = r_row;
        w_col_n        = r_col;
        w_we_n         = 1'b0;
        w_frame_done_n = 1'b0;
        w_data_n       = r_data;
        case (r_state)
            IDLE: begin
                if (r_full[r_rsel]) begin
                    w_state_n = WRITE;
                    w_row_n   = '0;
                    w_col_n   = '0;
                end
            end
            WRITE: begin
                if (w_accept) begin
                    if (r_col == 2'd2) begin
                        w_col_n = '0;
                        if (r_row == 2'd2) begin
                            w_row_n   = '0;
                            w_state_n = DONE;
                        end else begin
                            w_row_n = r_row + 2'd1;
                        end
                    end else begin
                        w_col_n = r_col + 2'd1;
                    end
                end
            end
            DONE: begin
                w_state_n = IDLE;
                w_rsel_n  = ~r_rsel;
            end
            default: w_state_n = IDLE;
        endcase
        w_idx = CW'(w_row_n) * CW'(3) + CW'(w_col_n);
        if (w_state_n == WRITE) begin
            w_we_n   = 1'b1;
            w_data_n = r_buf[r_rsel][w_idx];
        end
        w_frame_done_n = (w_state_n == DONE);
    end

    assign bus.panel_data = r_data;
    assign bus.panel_row  = r_row;
    assign bus.panel_col  = r_col;
    assign bus.panel_we   = r_we;
    assign bus.frame_done = r_frame_done;
    assign bus.drop_err   = r_drop_err;
    assign bus.buf_level  = r_buf_level;
endmodule

// File: tb/tb_lcd_win_writer.sv
// Directed bench for lcd_win_writer: timing, stalls, overflow drops, gaps,
// mid-write reset and simultaneous capture/release.
module tb_lcd_win_writer;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    int   wr_data[$];
    int   wr_pos[$];
    int   wr_cyc[$];
    int   done_cyc[$];
    int   we_cnt = 0;

    lcd_win_writer_if #(.DW(8)) bus();

    lcd_win_writer #(.DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Panel-side log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.panel_we === 1'b1) we_cnt++;
        if (bus.panel_we === 1'b1 && bus.panel_ready === 1'b1) begin
            wr_data.push_back(int'(bus.panel_data));
            wr_pos.push_back(int'(bus.panel_row) * 3 + int'(bus.panel_col));
            wr_cyc.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_pos.delete();
        wr_cyc.delete();
        done_cyc.delete();
        we_cnt = 0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.pix_in      = '0;
        bus.panel_ready = 1'b1;
        tick();
        tick();
        clear_log();
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int gap);
        for (int i = 0; i < 9; i++) begin
            bus.pix_in    = base + 8'(i);
            bus.pix_valid = 1'b1;
            tick();
            bus.pix_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        int b;
        b = budget;
        while (wr_data.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk("write_count", 32'(wr_data.size()), 32'(n));
    endtask

    task automatic chk_frame(input int first, input logic [7:0] base, input int start);
        for (int i = 0; i < 9; i++) begin
            if (first + i < wr_data.size()) begin
                chk($sformatf("data[%0d]", first + i), 32'(wr_data[first + i]), 32'(base + 8'(i)));
                chk($sformatf("pos[%0d]", first + i), 32'(wr_pos[first + i]), 32'(i));
                if (start >= 0)
                    chk($sformatf("cyc[%0d]", first + i), 32'(wr_cyc[first + i]), 32'(start + i));
            end
        end
    endtask

    initial begin
        int t0;
        int t1;

        // Reset values and single frame with ready held high
        do_reset();
        t0 = cyc;
        chk("rst_we", 32'(bus.panel_we), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_drop", 32'(bus.drop_err), 32'd0);
        chk("rst_level", 32'(bus.buf_level), 32'd0);
        chk("rst_data", 32'(bus.panel_data), 32'd0);
        chk("rst_row", 32'(bus.panel_row), 32'd0);
        chk("rst_col", 32'(bus.panel_col), 32'd0);
        send_frame(8'd1, 0);
        wait_writes(9, 30);
        repeat (3) tick();
        chk_frame(0, 8'd1, t0 + 10);
        chk("single_done_n", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) chk("single_done_cyc", 32'(done_cyc[0]), 32'(t0 + 19));
        chk("single_drop", 32'(bus.drop_err), 32'd0);
        chk("single_we_low", 32'(bus.panel_we), 32'd0);

        // Panel stall on the 4th pixel
        do_reset();
        t0 = cyc;
        send_frame(8'd1, 0);
        while (cyc < t0 + 13) tick();
        bus.panel_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stall_we", 32'(bus.panel_we), 32'd1);
            chk("stall_data", 32'(bus.panel_data), 32'd4);
            chk("stall_row", 32'(bus.panel_row), 32'd1);
            chk("stall_col", 32'(bus.panel_col), 32'd0);
            tick();
        end
        bus.panel_ready = 1'b1;
        wait_writes(9, 30);
        repeat (3) tick();
        chk_frame(0, 8'd1, -1);
        if (wr_cyc.size() == 9) begin
            chk("stall_cyc2", 32'(wr_cyc[2]), 32'(t0 + 12));
            chk("stall_cyc3", 32'(wr_cyc[3]), 32'(t0 + 16));
            chk("stall_cyc8", 32'(wr_cyc[8]), 32'(t0 + 21));
        end
        if (done_cyc.size() > 0) chk("stall_done_cyc", 32'(done_cyc[0]), 32'(t0 + 22));
        chk("stall_we_cycles", 32'(we_cnt), 32'd12);

        // Overflow: three frames into two buffers with the panel stalled
        do_reset();
        bus.panel_ready = 1'b0;
        send_frame(8'h10, 0);
        repeat (2) tick();
        send_frame(8'h20, 0);
        repeat (2) tick();
        chk("ovf_level2", 32'(bus.buf_level), 32'd2);
        chk("ovf_drop_pre", 32'(bus.drop_err), 32'd0);
        send_frame(8'h30, 0);
        chk("ovf_drop", 32'(bus.drop_err), 32'd1);
        chk("ovf_level_hold", 32'(bus.buf_level), 32'd2);
        chk("ovf_no_writes", 32'(wr_data.size()), 32'd0);
        bus.panel_ready = 1'b1;
        wait_writes(18, 60);
        repeat (3) tick();
        chk_frame(0, 8'h10, -1);
        chk_frame(9, 8'h20, -1);
        chk("ovf_done_n", 32'(done_cyc.size()), 32'd2);
        chk("ovf_level0", 32'(bus.buf_level), 32'd0);
        send_frame(8'h40, 0);
        wait_writes(27, 40);
        chk_frame(18, 8'h40, -1);
        chk("ovf_drop_sticky", 32'(bus.drop_err), 32'd1);

        // Gapped input
        do_reset();
        t0 = cyc;
        send_frame(8'd1, 1);
        wait_writes(9, 30);
        chk_frame(0, 8'd1, t0 + 18);

        // Reset during the 5th panel write
        do_reset();
        t0 = cyc;
        send_frame(8'h50, 0);
        while (cyc < t0 + 14) tick();
        chk("mid_we_before", 32'(bus.panel_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_we", 32'(bus.panel_we), 32'd0);
        chk("mid_level", 32'(bus.buf_level), 32'd0);
        chk("mid_drop", 32'(bus.drop_err), 32'd0);
        clear_log();
        t1 = cyc;
        send_frame(8'hA0, 0);
        wait_writes(9, 30);
        repeat (3) tick();
        chk_frame(0, 8'hA0, t1 + 10);
        chk("mid_done_n", 32'(done_cyc.size()), 32'd1);

        // Frame B completes in the cycle frame A is in DONE
        do_reset();
        t0 = cyc;
        send_frame(8'hC0, 0);
        while (cyc < t0 + 11) tick();
        send_frame(8'hB0, 0);
        chk("sim_level_a", 32'(bus.buf_level), 32'd1);
        tick();
        chk("sim_level_b", 32'(bus.buf_level), 32'd1);
        chk("sim_we", 32'(bus.panel_we), 32'd1);
        wait_writes(18, 30);
        chk_frame(0, 8'hC0, t0 + 10);
        chk_frame(9, 8'hB0, t0 + 21);
        if (done_cyc.size() > 0) chk("sim_done_cyc", 32'(done_cyc[0]), 32'(t0 + 19));
        chk("sim_drop", 32'(bus.drop_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
